// File: rtl/btn_reader.sv
// Button reader: synchronizes and debounces a raw pad, then reports
// the held level and press/release/short/long strobes.
//
// Ports:
//   clk           system clock, rising edge
//   rst           synchronous active-high reset
//   btn_in        raw asynchronous button pad (may bounce)
//   pressed       debounced level, 1 = held
//   press_pulse   one-cycle strobe on qualified press
//   release_pulse one-cycle strobe on qualified release
//   short_pulse   one-cycle strobe on release without a long press
//   long_pulse    one-cycle strobe when the hold reaches LONG_CYCLES
module btn_reader #(
  parameter int unsigned DEBOUNCE_CYCLES = 160000,
  parameter int unsigned LONG_CYCLES     = 8000000,
  parameter bit          ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic pressed,
  output logic press_pulse,
  output logic release_pulse,
  output logic short_pulse,
  output logic long_pulse
);

  localparam int unsigned DW =
    (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int unsigned HW =
    (LONG_CYCLES > 2) ? $clog2(LONG_CYCLES) : 1;

  localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HLAST = HW'(LONG_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS_DB,
    HELD_SHORT,
    HELD_LONG,
    REL_DB
  } state_t;

  logic s1;
  logic s2;
  logic btn_s;

  state_t        state;
  state_t        state_n;
  logic [DW-1:0] dcnt;
  logic [DW-1:0] dcnt_n;
  logic [HW-1:0] hcnt;
  logic [HW-1:0] hcnt_n;
  logic          long_seen;
  logic          long_seen_n;

  logic pressed_n;
  logic press_n;
  logic release_n;
  logic short_n;
  logic long_n;

  logic          hsat;
  logic [HW-1:0] hinc;

  // Synchronizer parks at the idle pad level so reset never looks
  // like a press.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= ACTIVE_LOW;
      s2 <= ACTIVE_LOW;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
    end
  end

  assign btn_s = s2 ^ ACTIVE_LOW;

  assign hsat = (hcnt == HLAST);
  assign hinc = hsat ? hcnt : hcnt + HW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      dcnt          <= '0;
      hcnt          <= '0;
      long_seen     <= 1'b0;
      pressed       <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      short_pulse   <= 1'b0;
      long_pulse    <= 1'b0;
    end else begin
      state         <= state_n;
      dcnt          <= dcnt_n;
      hcnt          <= hcnt_n;
      long_seen     <= long_seen_n;
      pressed       <= pressed_n;
      press_pulse   <= press_n;
      release_pulse <= release_n;
      short_pulse   <= short_n;
      long_pulse    <= long_n;
    end
  end

  always_comb begin
    state_n     = state;
    dcnt_n      = dcnt;
    hcnt_n      = hcnt;
    long_seen_n = long_seen;
    pressed_n   = pressed;
    press_n     = 1'b0;
    release_n   = 1'b0;
    short_n     = 1'b0;
    long_n      = 1'b0;

    unique case (state)
      IDLE: begin
        if (btn_s) begin
          state_n = PRESS_DB;
          dcnt_n  = '0;
        end
      end

      PRESS_DB: begin
        if (!btn_s) begin
          state_n = IDLE;
        end else if (dcnt == DLAST) begin
          state_n     = HELD_SHORT;
          pressed_n   = 1'b1;
          press_n     = 1'b1;
          hcnt_n      = '0;
          long_seen_n = 1'b0;
        end else begin
          dcnt_n = dcnt + DW'(1);
        end
      end

      // Release has priority over reaching the long threshold.
      HELD_SHORT: begin
        if (!btn_s) begin
          state_n = REL_DB;
          dcnt_n  = '0;
          hcnt_n  = hinc;
        end else if (hsat) begin
          state_n     = HELD_LONG;
          long_n      = 1'b1;
          long_seen_n = 1'b1;
        end else begin
          hcnt_n = hinc;
        end
      end

      HELD_LONG: begin
        if (!btn_s) begin
          state_n = REL_DB;
          dcnt_n  = '0;
        end
      end

      // Hold count is frozen while the release is being qualified.
      REL_DB: begin
        if (btn_s) begin
          state_n = long_seen ? HELD_LONG : HELD_SHORT;
        end else if (dcnt == DLAST) begin
          state_n   = IDLE;
          pressed_n = 1'b0;
          release_n = 1'b1;
          short_n   = !long_seen;
        end else begin
          dcnt_n = dcnt + DW'(1);
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_btn_reader.sv
// Scoreboard bench for btn_reader with DEBOUNCE_CYCLES=4,
// LONG_CYCLES=20, ACTIVE_LOW=1.
module tb_btn_reader;

  logic clk = 1'b0;
  logic rst;
  logic btn_in;
  logic pressed;
  logic press_pulse;
  logic release_pulse;
  logic short_pulse;
  logic long_pulse;

  always #5 clk = ~clk;

  btn_reader #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES(20),
    .ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btn_in),
    .pressed(pressed),
    .press_pulse(press_pulse),
    .release_pulse(release_pulse),
    .short_pulse(short_pulse),
    .long_pulse(long_pulse)
  );

  // strobe order: {press, release, short, long}
  localparam logic [3:0] EP  = 4'b1000;
  localparam logic [3:0] ERS = 4'b0110;
  localparam logic [3:0] ER  = 4'b0100;
  localparam logic [3:0] EL  = 4'b0001;

  typedef struct {
    int         at;
    logic [3:0] s;
  } ev_t;

  ev_t q[$];
  int  cyc = 0;
  int  total = 0;
  int  passed = 0;
  logic exp_pressed = 1'b0;

  function automatic void sched(input int at, input logic [3:0] s);
    ev_t e;
    e.at = at;
    e.s  = s;
    q.push_back(e);
  endfunction

  function automatic void apply(input logic [3:0] s);
    if (s[3]) exp_pressed = 1'b1;
    if (s[2]) exp_pressed = 1'b0;
  endfunction

  // Monitor: runs 1 time unit after each rising edge.
  initial begin
    logic [3:0] st;
    ev_t e;
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      st = {press_pulse, release_pulse, short_pulse, long_pulse};
      if (rst) begin
        exp_pressed = 1'b0;
        total++;
        if ({pressed, st} === 5'b0) passed++;
        else $display("FAIL reset_outputs edge %0d: got %b want 00000",
                      cyc, {pressed, st});
      end else begin
        while (q.size() > 0 && q[0].at < cyc) begin
          e = q.pop_front();
          total++;
          $display("FAIL missed_event edge %0d: got none want %b",
                   e.at, e.s);
          apply(e.s);
        end
        if (q.size() > 0 && q[0].at == cyc) begin
          e = q.pop_front();
          total++;
          if (st === e.s) passed++;
          else $display("FAIL strobes edge %0d: got %b want %b",
                        cyc, st, e.s);
          apply(e.s);
        end else if (st !== 4'b0) begin
          total++;
          $display("FAIL spurious_strobe edge %0d: got %b want 0000",
                   cyc, st);
        end
        total++;
        if (pressed === exp_pressed) passed++;
        else $display("FAIL pressed edge %0d: got %b want %b",
                      cyc, pressed, exp_pressed);
      end
    end
  end

  // Drive btn_in now (at a falling edge) and hold it n cycles.
  task automatic seg(input logic lvl, input int n);
    btn_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int b;
    rst    = 1'b1;
    btn_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    seg(1'b1, 5);

    // bounce: never qualifies
    seg(1'b0, 3);
    seg(1'b1, 1);
    seg(1'b0, 3);
    seg(1'b1, 15);

    // short press
    b = cyc + 1;
    sched(b + 6, EP);
    sched(b + 16, ERS);
    seg(1'b0, 10);
    seg(1'b1, 15);

    // long press
    b = cyc + 1;
    sched(b + 6, EP);
    sched(b + 26, EL);
    sched(b + 46, ER);
    seg(1'b0, 40);
    seg(1'b1, 15);

    // release glitch while short-held: long delayed by 2
    b = cyc + 1;
    sched(b + 6, EP);
    sched(b + 28, EL);
    sched(b + 41, ER);
    seg(1'b0, 10);
    seg(1'b1, 2);
    seg(1'b0, 23);
    seg(1'b1, 15);

    // release seen exactly at hold threshold: release wins
    b = cyc + 1;
    sched(b + 6, EP);
    sched(b + 30, ERS);
    seg(1'b0, 24);
    seg(1'b1, 15);

    // reset mid-hold, button still held afterwards
    b = cyc + 1;
    sched(b + 6, EP);
    seg(1'b0, 12);
    rst = 1'b1;
    seg(1'b0, 1);
    rst = 1'b0;
    sched(b + 19, EP);
    sched(b + 31, ERS);
    seg(1'b0, 12);
    seg(1'b1, 15);

    seg(1'b1, 5);
    total++;
    if (q.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: got %0d pending want 0",
                  q.size());

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
